// File: rtl/mul_issue_scheduler.sv
// Issue scheduler for the multi-cycle multiplier: launches a MUL, tracks its destination,
// raises hazards for dependent instructions and arbitrates the regfile write port.
// Optional build macro: MUL_DONE_EXT_EN (BUSY ends on mul_done, counter becomes a watchdog).
module mul_issue_scheduler #(
    parameter int MUL_CYCLES = 4,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wr_regfile,
    input  logic                  id_mul_start,
    input  logic                  id_jmp,
    input  logic                  ex_branch_taken,
    input  logic                  pipe_wb_active,
    input  logic                  mul_done,
    output logic                  mul_start,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush_ifid,
    output logic                  mul_wb_en,
    output logic [REG_ADDR_W-1:0] mul_wb_rd,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam int CNT_W = 8;
`ifdef MUL_DONE_EXT_EN
    localparam int LOAD_VAL = 4 * MUL_CYCLES - 1;
`else
    localparam int LOAD_VAL = MUL_CYCLES - 1;
`endif
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_VAL);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             raw_hit;
    logic             waw_hit;
    logic             hz;

`ifndef MUL_DONE_EXT_EN
    logic unused_mul_done;
    assign unused_mul_done = mul_done;
`endif

    // The ID instruction is offered by id_valid and consumed in any cycle where
    // stall is low; while stall is high ID must hold the same instruction.
    always_comb begin
        raw_hit = (mul_wb_rd != '0) && ((id_rs == mul_wb_rd) || (id_rt == mul_wb_rd));
        waw_hit = id_wr_regfile && (id_rd == mul_wb_rd);
        hz      = (state != IDLE) && id_valid && (raw_hit || waw_hit || id_mul_start);
    end

    // A taken branch kills the stall; a JMP only flushes when it is not itself stalled.
    assign stall      = hz && !ex_branch_taken;
    assign bubble     = stall;
    assign flush_ifid = ex_branch_taken || (id_valid && id_jmp && !stall);
    assign busy       = (state != IDLE);
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mul_wb_rd <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                mul_wb_rd <= id_rd;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        mul_start  = 1'b0;
        mul_wb_en  = 1'b0;
        case (state)
            IDLE: begin
                if (id_valid && id_mul_start && !stall && !flush_ifid) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                mul_start  = 1'b1;
                cnt_next   = CNT_LOAD;
                state_next = BUSY;
            end
            BUSY: begin
`ifdef MUL_DONE_EXT_EN
                if (mul_done) begin
                    state_next = WB;
                end else if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
`else
                if (cnt == '0) begin
                    state_next = WB;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
`endif
            end
            WB: begin
                // Pipeline writeback owns the port; a result for r0 is dropped silently.
                if (!pipe_wb_active) begin
                    mul_wb_en  = (mul_wb_rd != '0);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mul_issue_scheduler.sv
// Bench for mul_issue_scheduler: directed scenarios with cycle-indexed expectations,
// then randomized traffic checked against a cycle-count reference model.
module tb_mul_issue_scheduler;

    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic [4:0] id_rd = '0;
    logic       id_wr_regfile = 1'b0;
    logic       id_mul_start = 1'b0;
    logic       id_jmp = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       pipe_wb_active = 1'b0;
    logic       mul_done = 1'b0;
    logic       mul_start;
    logic       stall;
    logic       bubble;
    logic       flush_ifid;
    logic       mul_wb_en;
    logic [4:0] mul_wb_rd;
    logic       busy;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    mul_issue_scheduler #(.MUL_CYCLES(MC), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_wr_regfile(id_wr_regfile), .id_mul_start(id_mul_start),
        .id_jmp(id_jmp), .ex_branch_taken(ex_branch_taken), .pipe_wb_active(pipe_wb_active),
        .mul_done(mul_done), .mul_start(mul_start), .stall(stall), .bubble(bubble),
        .flush_ifid(flush_ifid), .mul_wb_en(mul_wb_en), .mul_wb_rd(mul_wb_rd),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

    function automatic logic [5:0] outs();
        return {mul_start, busy, stall, bubble, flush_ifid, mul_wb_en};
    endfunction

    task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic wr, input logic mul,
                          input logic jmp, input logic br, input logic pwb);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_wr_regfile = wr;
        id_mul_start = mul; id_jmp = jmp; ex_branch_taken = br; pipe_wb_active = pwb;
    endtask

    task automatic clear_in();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mul_done = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_in();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({outs(), mul_wb_rd, state_dbg} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state outs=%b rd=%0d st=%0d required all 0", outs(), mul_wb_rd, state_dbg);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [5:0] e;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k == 0)      set_in(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 0);
            else if (k == 1) set_in(1, 5'd5, 5'd6, 5'd7, 1, 0, 0, 0, 0);
            else             set_in(1, 5'd3, 5'd6, 5'd8, 1, 0, 0, 0, 0);
            #1;
            e = {k == 1, k >= 1 && k <= 6, k >= 2 && k <= 6, k >= 2 && k <= 6, 1'b0, k == 6};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL basic k=%0d outs=%b required=%b", k, outs(), e);
            end
            if (k == 6) begin
                checks++;
                if (mul_wb_rd !== 5'd3) begin
                    errors++;
                    $display("FAIL basic_wb_rd got=%0d required=3", mul_wb_rd);
                end
            end
        end
        clear_in();
    endtask

    task automatic test_wb_hold();
        logic [5:0] e;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 0)                 set_in(1, 5'd0, 5'd0, 5'd4, 1, 1, 0, 0, 0);
            else if (k >= 6 && k <= 7)  set_in(1, 5'd1, 5'd4, 5'd10, 1, 0, 0, 0, 1);
            else if (k >= 8)            set_in(1, 5'd1, 5'd4, 5'd10, 1, 0, 0, 0, 0);
            else                        clear_in();
            #1;
            e = {k == 1, k >= 1 && k <= 8, k >= 6 && k <= 8, k >= 6 && k <= 8, 1'b0, k == 8};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL wb_hold k=%0d outs=%b required=%b", k, outs(), e);
            end
        end
        clear_in();
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k == 0)                set_in(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 0);
            else if (k >= 2 && k <= 7) set_in(1, 5'd1, 5'd2, 5'd9, 1, 1, 0, 0, 0);
            else                       clear_in();
            #1;
            e = {k == 1 || k == 8, (k >= 1 && k <= 6) || (k >= 8 && k <= 13),
                 k >= 2 && k <= 6, k >= 2 && k <= 6, 1'b0, k == 6 || k == 13};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL back_to_back k=%0d outs=%b required=%b", k, outs(), e);
            end
            if (k == 13) begin
                checks++;
                if (mul_wb_rd !== 5'd9) begin
                    errors++;
                    $display("FAIL back_to_back_rd got=%0d required=9", mul_wb_rd);
                end
            end
        end
        clear_in();
    endtask

    task automatic test_flush();
        logic [5:0] e;
        logic       st;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            case (k)
                0: set_in(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0);
                1: set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
                3: set_in(1, 5'd0, 5'd0, 5'd2, 1, 1, 0, 0, 0);
                5: set_in(1, 5'd2, 5'd0, 5'd0, 0, 0, 1, 0, 0);
                6: set_in(1, 5'd2, 5'd0, 5'd11, 1, 0, 0, 1, 0);
                default: clear_in();
            endcase
            #1;
            st = (k == 5);
            e = {k == 4, k >= 4 && k <= 9, st, st, k == 0 || k == 1 || k == 6, k == 9};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL flush k=%0d outs=%b required=%b", k, outs(), e);
            end
        end
        clear_in();
    endtask

    task automatic test_reset_mid();
        logic [5:0] e;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 0) set_in(1, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0, 0);
            else        clear_in();
            rst = (k == 4);
            #1;
            e = {k == 1, k >= 1 && k <= 4, 1'b0, 1'b0, 1'b0, 1'b0};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL reset_mid k=%0d outs=%b required=%b", k, outs(), e);
            end
            if (k == 5) begin
                checks++;
                if (mul_wb_rd !== 5'd0) begin
                    errors++;
                    $display("FAIL reset_mid_rd got=%0d required=0", mul_wb_rd);
                end
            end
        end
        rst = 1'b0;
        clear_in();
    endtask

    task automatic test_rd_zero();
        logic [5:0] e;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            if (k == 0)                set_in(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
            else if (k >= 2 && k <= 5) set_in(1, 5'd0, 5'd0, 5'd1, 1, 0, 0, 0, 0);
            else if (k == 6)           set_in(1, 5'd1, 5'd1, 5'd0, 1, 0, 0, 0, 0);
            else                       clear_in();
            #1;
            e = {k == 1, k >= 1 && k <= 6, k == 6, k == 6, 1'b0, 1'b0};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL rd_zero k=%0d outs=%b required=%b", k, outs(), e);
            end
        end
        clear_in();
    endtask

`ifdef MUL_DONE_EXT_EN
    task automatic test_mul_done_ext();
        logic [5:0] e;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) set_in(1, 5'd0, 5'd0, 5'd3, 1, 1, 0, 0, 0);
            else        clear_in();
            mul_done = (k == 3);
            #1;
            e = {k == 1, k >= 1 && k <= 4, 1'b0, 1'b0, 1'b0, k == 4};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL done_ext k=%0d outs=%b required=%b", k, outs(), e);
            end
        end
        for (int k = 0; k <= 19; k++) begin
            @(negedge clk);
            if (k == 0) set_in(1, 5'd0, 5'd0, 5'd6, 1, 1, 0, 0, 0);
            else        clear_in();
            mul_done = (k == 1 || k == 18);
            #1;
            e = {k == 1, k >= 1 && k <= 4 * MC + 1, 1'b0, 1'b0, 1'b0, 1'b0};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL watchdog k=%0d outs=%b required=%b", k, outs(), e);
            end
        end
        clear_in();
    endtask
`endif

    // Reference: an outstanding MUL accepted at cycle acc issues at acc+1 and may
    // write back from acc+MC+2 onward, the first such cycle with the port free.
    task automatic test_random();
        int         cyc = 0;
        int         acc = 0;
        logic       act = 1'b0;
        logic [4:0] mrd = '0;
        logic       in_wb, hz, e_st, e_fl;
        logic [5:0] e;
        @(negedge clk);
        clear_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (cyc = 0; cyc < 500; cyc++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                   $urandom_range(0, 2) == 0);
            if (act && cyc == acc + MC + 1)
                mul_done = 1'b1;
            else if (!act || cyc <= acc + 1 || cyc >= acc + MC + 2)
                mul_done = ($urandom_range(0, 1) == 1);
            else
                mul_done = 1'b0;
            #1;
            in_wb = act && (cyc >= acc + MC + 2);
            hz = act && id_valid && (((mrd != 0) && (id_rs == mrd || id_rt == mrd)) ||
                                     (id_wr_regfile && id_rd == mrd) || id_mul_start);
            if (ex_branch_taken) begin
                e_st = 1'b0;
                e_fl = 1'b1;
            end else begin
                e_st = hz;
                e_fl = id_valid && id_jmp && !hz;
            end
            e = {act && cyc == acc + 1, act, e_st, e_st, e_fl, in_wb && !pipe_wb_active && mrd != 0};
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL random cyc=%0d outs=%b required=%b", cyc, outs(), e);
            end
            checks++;
            if (mul_wb_rd !== mrd) begin
                errors++;
                $display("FAIL random_rd cyc=%0d got=%0d required=%0d", cyc, mul_wb_rd, mrd);
            end
            if (rst) begin
                act = 1'b0;
                mrd = '0;
            end else if (in_wb && !pipe_wb_active) begin
                act = 1'b0;
            end else if (!act && id_valid && id_mul_start && !e_fl) begin
                act = 1'b1;
                acc = cyc;
                mrd = id_rd;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        clear_in();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wb_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_rd_zero();
`ifdef MUL_DONE_EXT_EN
        test_mul_done_ext();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
